// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexed Izhikevich neuron array: one shared 2.16 fixed-point update datapath
// sweeps every neuron once per tick, in ascending index order.
module izh_neuron_scheduler #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned AW          = $clog2(NUM_NEURONS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tick_i,
    input  logic                   clr_i,
    input  logic                   cfg_we_i,
    input  logic [AW-1:0]          cfg_addr_i,
    input  logic [2:0]             cfg_sel_i,
    input  logic [17:0]            cfg_wdata_i,
    output logic                   cfg_ready_o,
    output logic                   cfg_err_o,
    output logic                   busy_o,
    output logic                   step_done_o,
    output logic                   tick_overrun_o,
    output logic [NUM_NEURONS-1:0] spike_vec_o,
    input  logic [AW-1:0]          mon_sel_i,
    output logic [7:0]             mon_v_o
);

    localparam int N = int'(NUM_NEURONS);

    localparam logic signed [17:0] VRst   = 18'sh34CCD;
    localparam logic signed [17:0] URst   = 18'sh3CCCD;
    localparam logic signed [17:0] CRst   = 18'sh38000;
    localparam logic signed [17:0] DRst   = 18'sh0051E;
    localparam logic signed [17:0] VPeak  = 18'sh04CCC;
    localparam logic signed [17:0] KConst = 18'sh16666;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCommit,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;

    // Neuron state file and per-neuron configuration
    logic [17:0]     v_q [N];
    logic [17:0]     u_q [N];
    logic [3:0]      a_q [N];
    logic [3:0]      b_q [N];
    logic [17:0]     c_q [N];
    logic [17:0]     d_q [N];
    logic [7:0]      i_q [N];

    // Pipeline registers loaded in FETCH, consumed in COMMIT
    logic [17:0]     pv_q, pu_q, pc_q, pd_q;
    logic [3:0]      pa_q, pb_q;
    logic [7:0]      pi_q;

    logic [N-1:0]    acc_q;
    logic [N-1:0]    spike_q;
    logic            cfg_err_q;
    logic            overrun_q;
    logic [7:0]      mon_q;

    logic            busy;
    logic            cfg_acc;

    assign busy    = (state_q == StFetch) || (state_q == StCommit);
    assign cfg_acc = cfg_we_i && !busy && !clr_i;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (tick_i) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            StFetch: state_d = StCommit;
            StCommit: begin
                if (idx_q == AW'(NUM_NEURONS - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Soft clear aborts any sweep and wins over a same-cycle tick
        if (clr_i) begin
            state_d = StIdle;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Update datapath
    // ------------------------------------------------------------------
    logic signed [17:0] v_s, u_s, c_s, d_s;
    logic signed [35:0] prod;
    logic signed [17:0] vv, iw, v_sh2, u_sh2, iw_sh2, k_sh2, sum, v_new;
    logic signed [17:0] v_shb, du, u_new;
    logic signed [17:0] v_wr, u_wr;
    logic               spike;
    logic               unused_prod;

    assign v_s = $signed(pv_q);
    assign u_s = $signed(pu_q);
    assign c_s = $signed(pc_q);
    assign d_s = $signed(pd_q);

    assign prod        = v_s * v_s;
    assign vv          = {prod[35], prod[32:16]};
    assign unused_prod = ^{prod[34:33], prod[15:0]};
    assign iw          = {pi_q, 10'h000};

    assign v_sh2  = v_s >>> 2;
    assign u_sh2  = u_s >>> 2;
    assign iw_sh2 = iw >>> 2;
    assign k_sh2  = KConst >>> 2;
    assign sum    = vv + v_s + v_sh2 + k_sh2 - u_sh2 + iw_sh2;
    assign v_new  = v_s + (sum >>> 2);

    assign v_shb  = v_s >>> pb_q;
    assign du     = v_shb - u_s;
    assign u_new  = u_s + ((du >>> pa_q) >>> 4);

    assign spike  = v_s > VPeak;
    assign v_wr   = spike ? c_s : v_new;
    assign u_wr   = spike ? (u_s + d_s) : u_new;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv_q <= '0;
            pu_q <= '0;
            pa_q <= '0;
            pb_q <= '0;
            pc_q <= '0;
            pd_q <= '0;
            pi_q <= '0;
        end else if (state_q == StFetch) begin
            pv_q <= v_q[idx_q];
            pu_q <= u_q[idx_q];
            pa_q <= a_q[idx_q];
            pb_q <= b_q[idx_q];
            pc_q <= c_q[idx_q];
            pd_q <= d_q[idx_q];
            pi_q <= i_q[idx_q];
        end
    end

    // ------------------------------------------------------------------
    // Neuron state file: clear, write-back and config writes of v/u
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < N; n++) begin
                v_q[n] <= VRst;
                u_q[n] <= URst;
            end
        end else if (clr_i) begin
            for (int n = 0; n < N; n++) begin
                v_q[n] <= VRst;
                u_q[n] <= URst;
            end
        end else if (state_q == StCommit) begin
            v_q[idx_q] <= v_wr;
            u_q[idx_q] <= u_wr;
        end else if (cfg_acc) begin
            if (cfg_sel_i == 3'd4) v_q[cfg_addr_i] <= cfg_wdata_i;
            if (cfg_sel_i == 3'd5) u_q[cfg_addr_i] <= cfg_wdata_i;
        end
    end

    // Configuration survives a soft clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < N; n++) begin
                a_q[n] <= 4'd1;
                b_q[n] <= 4'd2;
                c_q[n] <= CRst;
                d_q[n] <= DRst;
                i_q[n] <= '0;
            end
        end else if (cfg_acc) begin
            unique case (cfg_sel_i)
                3'd0: begin
                    a_q[cfg_addr_i] <= cfg_wdata_i[3:0];
                    b_q[cfg_addr_i] <= cfg_wdata_i[7:4];
                end
                3'd1:    c_q[cfg_addr_i] <= cfg_wdata_i;
                3'd2:    d_q[cfg_addr_i] <= cfg_wdata_i;
                3'd3:    i_q[cfg_addr_i] <= cfg_wdata_i[7:0];
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Spike accumulation, status pulses and monitor
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            spike_q   <= '0;
            cfg_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clr_i) begin
            acc_q     <= '0;
            spike_q   <= '0;
            cfg_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i && busy;
            overrun_q <= tick_i && (state_q != StIdle);
            if (state_q == StCommit && spike) begin
                acc_q[idx_q] <= 1'b1;
            end
            if (state_q == StDone) begin
                spike_q <= acc_q;
                acc_q   <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mon_q <= '0;
        end else begin
            mon_q <= v_q[mon_sel_i][17:10];
        end
    end

    assign busy_o         = busy;
    assign cfg_ready_o    = !busy;
    assign step_done_o    = (state_q == StDone);
    assign cfg_err_o      = cfg_err_q;
    assign tick_overrun_o = overrun_q;
    assign spike_vec_o    = spike_q;
    assign mon_v_o        = mon_q;

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Randomized bench for izh_neuron_scheduler: an integer-arithmetic neuron model predicts
// every sweep; scenario tasks cover timing, overrun, soft clear and async reset.
module tb_izh_neuron_scheduler;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int K4 = 22937;  // 0x16666 >>> 2

    logic          clk, rst_n, tick, clr, cfg_we;
    logic [AW-1:0] cfg_addr, mon_sel;
    logic [2:0]    cfg_sel;
    logic [17:0]   cfg_wdata;
    logic          cfg_ready, cfg_err, busy, step_done, tick_overrun;
    logic [N-1:0]  spike_vec;
    logic [7:0]    mon_v;

    int checks;
    int failures;

    int mv [N];
    int mu [N];
    int ma [N];
    int mb [N];
    int mc [N];
    int md [N];
    int mi [N];
    logic [N-1:0] mspk;

    izh_neuron_scheduler #(.NUM_NEURONS(N)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tick_i         (tick),
        .clr_i          (clr),
        .cfg_we_i       (cfg_we),
        .cfg_addr_i     (cfg_addr),
        .cfg_sel_i      (cfg_sel),
        .cfg_wdata_i    (cfg_wdata),
        .cfg_ready_o    (cfg_ready),
        .cfg_err_o      (cfg_err),
        .busy_o         (busy),
        .step_done_o    (step_done),
        .tick_overrun_o (tick_overrun),
        .spike_vec_o    (spike_vec),
        .mon_sel_i      (mon_sel),
        .mon_v_o        (mon_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int w18(input int x);
        int y;
        y = x & 262143;
        if (y >= 131072) y = y - 262144;
        return y;
    endfunction

    function automatic int f_vnew(input int v, input int u, input int i);
        longint p;
        int vv, iw, s;
        p  = longint'(v) * longint'(v);
        vv = int'((p >> 16) % 131072);
        iw = w18(i * 1024);
        s  = w18(vv + v + (v >>> 2) + K4 - (u >>> 2) + (iw >>> 2));
        return w18(v + (s >>> 2));
    endfunction

    function automatic int f_unew(input int v, input int u, input int a, input int b);
        int t;
        t = w18((v >>> b) - u);
        return w18(u + ((t >>> a) >>> 4));
    endfunction

    task automatic model_reset_state();
        for (int n = 0; n < N; n++) begin
            mv[n] = w18(32'h34CCD);
            mu[n] = w18(32'h3CCCD);
        end
        mspk = '0;
    endtask

    task automatic model_reset_all();
        model_reset_state();
        for (int n = 0; n < N; n++) begin
            ma[n] = 1; mb[n] = 2;
            mc[n] = w18(32'h38000); md[n] = 32'h0051E; mi[n] = 0;
        end
    endtask

    task automatic model_sweep();
        int v, u;
        mspk = '0;
        for (int n = 0; n < N; n++) begin
            v = mv[n];
            u = mu[n];
            if (v > 19660) begin
                mv[n]   = mc[n];
                mu[n]   = w18(u + md[n]);
                mspk[n] = 1'b1;
            end else begin
                mv[n] = f_vnew(v, u, mi[n]);
                mu[n] = f_unew(v, u, ma[n], mb[n]);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int addr, input int sel, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_sel   = 3'(sel);
        cfg_wdata = 18'(data);
        step();
        cfg_we    = 1'b0;
        case (sel)
            0: begin ma[addr] = data & 15; mb[addr] = (data >> 4) & 15; end
            1: mc[addr] = w18(data);
            2: md[addr] = w18(data);
            3: mi[addr] = data & 255;
            4: mv[addr] = w18(data);
            5: mu[addr] = w18(data);
            default: ;
        endcase
    endtask

    task automatic run_sweep(input string tag);
        int cyc, bad;
        tick = 1'b1;
        step();
        tick = 1'b0;
        cyc  = 1;
        bad  = 0;
        while (step_done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1 || cfg_ready !== 1'b0) bad++;
            step();
            cyc++;
        end
        checks++;
        if (cyc != 2 * N + 1) begin
            failures++;
            $display("FAIL %s sweep_latency actual=%0d required=%0d", tag, cyc, 2 * N + 1);
        end
        checks++;
        if (bad != 0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_window bad_cycles=%0d busy_at_done=%b required=0", tag, bad, busy);
        end
        model_sweep();
        step();
        step();
    endtask

    task automatic check_all(input string tag);
        checks++;
        if (spike_vec !== mspk) begin
            failures++;
            $display("FAIL %s spike_vec actual=%b required=%b", tag, spike_vec, mspk);
        end
        for (int n = 0; n < N; n++) begin
            checks++;
            if (dut.v_q[n] !== 18'(mv[n])) begin
                failures++;
                $display("FAIL %s v[%0d] actual=%h required=%h", tag, n, dut.v_q[n], 18'(mv[n]));
            end
            checks++;
            if (dut.u_q[n] !== 18'(mu[n])) begin
                failures++;
                $display("FAIL %s u[%0d] actual=%h required=%h", tag, n, dut.u_q[n], 18'(mu[n]));
            end
            mon_sel = AW'(n);
            step();
            checks++;
            if (mon_v !== 8'((mv[n] & 262143) >> 10)) begin
                failures++;
                $display("FAIL %s mon_v[%0d] actual=%h required=%h", tag, n, mon_v,
                         8'((mv[n] & 262143) >> 10));
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({busy, step_done, cfg_err, tick_overrun, spike_vec, mon_v, cfg_ready} !== 17'h1) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=%h",
                     {busy, step_done, cfg_err, tick_overrun, spike_vec, mon_v, cfg_ready}, 17'h1);
        end
        #3;
        rst_n = 1'b1;
        model_reset_all();
        step();
        for (int n = 0; n < N; n++) begin
            checks++;
            if ({dut.a_q[n], dut.b_q[n], dut.c_q[n], dut.d_q[n], dut.i_q[n]} !==
                {4'(ma[n]), 4'(mb[n]), 18'(mc[n]), 18'(md[n]), 8'(mi[n])}) begin
                failures++;
                $display("FAIL reset_cfg[%0d] actual=%h/%h/%h/%h/%h", n, dut.a_q[n], dut.b_q[n],
                         dut.c_q[n], dut.d_q[n], dut.i_q[n]);
            end
        end
        check_all("reset_state");
    endtask

    task automatic test_basic();
        cfg_write(0, 4, 0);
        cfg_write(0, 5, 0);
        run_sweep("basic0");
        check_all("basic0");
        mon_sel = 0;
        step();
        checks++;
        if (mon_v !== 8'h05 || dut.v_q[0] !== 18'h01666 || dut.u_q[0] !== 18'h0) begin
            failures++;
            $display("FAIL basic0_values v=%h u=%h mon=%h required v=01666 u=0 mon=05",
                     dut.v_q[0], dut.u_q[0], mon_v);
        end
        cfg_write(2, 4, 32'h05000);
        cfg_write(2, 5, 0);
        run_sweep("spike2");
        check_all("spike2");
        mon_sel = 2;
        step();
        checks++;
        if (spike_vec !== 4'b0100 || dut.v_q[2] !== 18'h38000 || dut.u_q[2] !== 18'h0051E ||
            mon_v !== 8'hE0) begin
            failures++;
            $display("FAIL spike2_values spk=%b v=%h u=%h mon=%h required 0100/38000/0051E/E0",
                     spike_vec, dut.v_q[2], dut.u_q[2], mon_v);
        end
    endtask

    task automatic test_threshold();
        cfg_write(1, 4, 32'h04CCC);
        run_sweep("thresh");
        checks++;
        if (spike_vec[1] !== 1'b0) begin
            failures++;
            $display("FAIL thresh_no_spike actual=%b required=0", spike_vec[1]);
        end
        check_all("thresh");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 4; w++) begin
                cfg_write($urandom_range(N - 1), $urandom_range(5), int'($urandom & 32'h3FFFF));
            end
            run_sweep("random");
            check_all("random");
            if (r[0]) begin
                run_sweep("random_b2b");
                check_all("random_b2b");
            end
        end
    endtask

    task automatic test_overrun();
        int n_ovr, n_err, n_done, cyc;
        logic [17:0] c3;
        cfg_write(3, 1, 32'h3A5A5);
        c3 = 18'(mc[3]);
        n_ovr = 0; n_err = 0; n_done = 0;
        tick = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (k == 1) tick = 1'b0;
            if (k == 4) begin tick = 1'b0; cfg_we = 1'b0; end
            n_ovr  += int'(tick_overrun);
            n_err  += int'(cfg_err);
            n_done += int'(step_done);
            if (k == 3) begin
                tick = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_sel = 3'd1; cfg_wdata = 18'h01234;
            end
        end
        model_sweep();
        checks++;
        if (n_ovr != 1 || n_err != 1 || n_done != 1) begin
            failures++;
            $display("FAIL overrun_pulses ovr=%0d err=%0d done=%0d required 1/1/1", n_ovr, n_err,
                     n_done);
        end
        checks++;
        if (dut.c_q[3] !== c3) begin
            failures++;
            $display("FAIL overrun_cfg_kept actual=%h required=%h", dut.c_q[3], c3);
        end
        check_all("overrun");
        // tick landing in the DONE cycle is dropped too
        tick = 1'b1;
        step();
        tick = 1'b0;
        cyc = 1;
        while (step_done !== 1'b1 && cyc < 100) begin step(); cyc++; end
        tick = 1'b1;
        step();
        tick = 1'b0;
        model_sweep();
        checks++;
        if (busy !== 1'b0 || tick_overrun !== 1'b1) begin
            failures++;
            $display("FAIL done_tick busy=%b overrun=%b required 0/1", busy, tick_overrun);
        end
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            n_done += int'(busy) + int'(step_done);
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL done_tick_no_queue actual=%0d required=0", n_done);
        end
        check_all("done_tick");
    endtask

    task automatic test_clr();
        int n_done;
        cfg_write(0, 1, 32'h2AAAA);
        cfg_write(1, 2, 32'h00777);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step(); step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL clr_busy actual=%b required=0", busy);
        end
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            n_done += int'(step_done);
            step();
        end
        checks++;
        if (n_done != 0) begin
            failures++;
            $display("FAIL clr_no_done actual=%0d required=0", n_done);
        end
        model_reset_state();
        checks++;
        if (dut.c_q[0] !== 18'(mc[0]) || dut.d_q[1] !== 18'(md[1])) begin
            failures++;
            $display("FAIL clr_cfg_kept c0=%h d1=%h required %h/%h", dut.c_q[0], dut.d_q[1],
                     18'(mc[0]), 18'(md[1]));
        end
        check_all("clr");
        // clr outranks tick and cfg_we in the same cycle
        clr = 1'b1; tick = 1'b1; cfg_we = 1'b1;
        cfg_addr = 2'd2; cfg_sel = 3'd1; cfg_wdata = 18'h11111;
        step();
        clr = 1'b0; tick = 1'b0; cfg_we = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_err !== 1'b0 || tick_overrun !== 1'b0 ||
            dut.c_q[2] !== 18'(mc[2])) begin
            failures++;
            $display("FAIL clr_priority busy=%b err=%b ovr=%b c2=%h required 0/0/0/%h", busy,
                     cfg_err, tick_overrun, dut.c_q[2], 18'(mc[2]));
        end
        run_sweep("after_clr");
        check_all("after_clr");
    endtask

    task automatic test_async_reset();
        cfg_write(0, 0, 32'h00035);
        cfg_write(3, 3, 32'h000C7);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step(); step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset_all();
        checks++;
        if ({busy, step_done, cfg_err, tick_overrun, spike_vec, mon_v, cfg_ready} !== 17'h1) begin
            failures++;
            $display("FAIL async_outputs actual=%h required=%h",
                     {busy, step_done, cfg_err, tick_overrun, spike_vec, mon_v, cfg_ready}, 17'h1);
        end
        checks++;
        if (dut.a_q[0] !== 4'(ma[0]) || dut.b_q[0] !== 4'(mb[0]) || dut.i_q[3] !== 8'(mi[3]) ||
            dut.v_q[1] !== 18'(mv[1])) begin
            failures++;
            $display("FAIL async_defaults a0=%h b0=%h i3=%h v1=%h", dut.a_q[0], dut.b_q[0],
                     dut.i_q[3], dut.v_q[1]);
        end
        #2;
        rst_n = 1'b1;
        step();
        run_sweep("after_rst");
        check_all("after_rst");
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b1; tick = 1'b0; clr = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_sel = '0; cfg_wdata = '0; mon_sel = '0;
        #2;
        test_reset();
        test_basic();
        test_threshold();
        test_random();
        test_overrun();
        test_clr();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/izh_neuron_scheduler.md
Name: izh_neuron_scheduler

Overview:
Time-multiplexes one Izhikevich update datapath (18-bit signed, 2.16 fixed point) across NUM_NEURONS neurons held in an internal state file. Each external tick triggers one sweep that updates every neuron once, in ascending index order. The block holds per-neuron parameters (a, b, c, d, I), written through a config port. It reports per-sweep spikes and a monitored membrane value.

Parameters:
NUM_NEURONS, 4, neurons in the state file (power of 2, 2..16)
AW, $clog2(NUM_NEURONS), neuron index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  start one sweep (single-cycle pulse)
clr  in  1  synchronous soft clear of neuron v/u state
cfg_we  in  1  config write strobe
cfg_addr  in  AW  target neuron
cfg_sel  in  3  field: 0 a/b {b[7:4],a[3:0]}, 1 c, 2 d, 3 I[7:0], 4 v, 5 u
cfg_wdata  in  18  write data
cfg_ready  out  1  high when writes are accepted (= !busy)
cfg_err  out  1  one-cycle pulse: write dropped because busy
busy  out  1  sweep in progress
step_done  out  1  one-cycle pulse at sweep end
tick_overrun  out  1  one-cycle pulse: tick dropped because busy
spike_vec  out  NUM_NEURONS  neurons that spiked in the last completed sweep
mon_sel  in  AW  neuron selected for monitoring
mon_v  out  8  registered v[17:10] of the selected neuron

Behaviour:
- Async reset values:
  - Every neuron: v=0x3_4CCD, u=0x3_CCCD.
  - Config per neuron: a=1, b=2, c=0x3_8000, d=0x0_051E, I=0.
  - FSM in IDLE. All outputs 0 except cfg_ready=1.
- FSM states: IDLE, FETCH, COMMIT, DONE.
  - IDLE: tick leads to FETCH with idx=0.
  - FETCH: latch v, u and config of neuron idx into pipeline registers; go to COMMIT.
  - COMMIT: write back the result. If idx=N-1, go to DONE; otherwise idx+1 and go to FETCH.
  - DONE: step_done=1, spike_vec <= sweep spike accumulator, clear the accumulator, then IDLE.
- Timing: tick sampled at edge 0 gives busy=1 from cycle 1 through 2N; step_done in cycle 2N+1; busy=0 from cycle 2N+1.
- Datapath, all terms 18-bit signed with arithmetic shifts:
  - vv = {prod[35], prod[32:16]}, where prod = v*v (36-bit).
  - Iw = {I, 10'h0}.
  - v_new = v + ((vv + v + (v>>>2) + (0x1_6666>>>2) - (u>>>2) + (Iw>>>2))>>>2).
  - u_new = u + ((((v>>>b) - u)>>>a)>>>4).
- Spike rule:
  - If v > 0x0_4CCC (signed, strict): write v <= c, u <= u + d, and set accumulator bit idx.
  - Otherwise write v <= v_new, u <= u_new.
  - Overflow wraps (no saturation).
- Config writes:
  - Applied on the edge where cfg_we && !busy.
  - If cfg_we && busy: write dropped and cfg_err pulses.
  - Writes in the same cycle as the tick that starts a sweep are applied; the sweep sees the new values.
- tick while busy (including the DONE cycle): dropped, tick_overrun pulses, no queued sweep.
- clr, any state:
  - All v/u return to reset values; config is kept.
  - Accumulator and spike_vec cleared; FSM goes to IDLE.
  - In-progress sweep aborted with no step_done.
  - clr has priority over tick and cfg_we in the same cycle; those are ignored and produce no error pulse.
- mon_v: registered one cycle after any change of mon_sel or the selected neuron's v.

Test Plan:
- Reset, write neuron 0 v=0, u=0 (I=0, b=2, a=1), tick -> step_done in cycle 9 (N=4), neuron 0 v=0x0_1666, u=0, mon_v (sel 0)=0x05, spike_vec=0.
- Write neuron 2 v=0x0_5000, u=0, tick -> after sweep, neuron 2 v=0x3_8000, u=0x0_051E, spike_vec=4'b0100, mon_v (sel 2)=0xE0.
- Write neuron 1 v=0x0_4CCC exactly, tick -> no spike (spike_vec[1]=0), v follows the v_new equation.
- Tick, then tick again 3 cycles later plus a cfg_we during busy -> one tick_overrun pulse, one cfg_err pulse, config unchanged, only one step_done.
- Tick, assert clr in cycle 4 -> busy=0 next cycle, no step_done, all v=0x3_4CCD, u=0x3_CCCD, written c/d preserved.
- Assert rst_n low mid-sweep (asynchronous, between edges) -> outputs immediately at reset values, config at defaults.
